// File: rtl/aud_if_pkg.sv
// aud_if_pkg: shared audio I2S types and defaults for the receive and transmit-side blocks
package aud_if_pkg;
  localparam int AUD_DATA_WIDTH  = 16;
  localparam int AUD_SLOT_BITS   = 32;
  localparam int AUD_SYNC_STAGES = 2;
  typedef enum logic [1:0] {SYNC_WAIT, RX_LEFT, RX_RIGHT} rx_state_e;
  function automatic int cnt_width(input int slot_bits);
    return $clog2(slot_bits + 1);
  endfunction
endpackage

// File: rtl/aud_i2s_rx_if.sv
// aud_i2s_rx_if: I2S serial inputs and recovered sample outputs; AUD_RX_FRAME_CHECK_EN adds oFRAME_ERR/oERR_CNT
interface aud_i2s_rx_if #(
  parameter int DATA_WIDTH = aud_if_pkg::AUD_DATA_WIDTH
);
  logic                  iAUD_BCK;
  logic                  iAUD_LRCK;
  logic                  iAUD_DAT;
  logic [DATA_WIDTH-1:0] oLEFT;
  logic [DATA_WIDTH-1:0] oRIGHT;
  logic                  oSAMPLE_VALID;
`ifdef AUD_RX_FRAME_CHECK_EN
  logic                  oFRAME_ERR;
  logic [7:0]            oERR_CNT;
  modport master (output iAUD_BCK, iAUD_LRCK, iAUD_DAT,
                  input  oLEFT, oRIGHT, oSAMPLE_VALID, oFRAME_ERR, oERR_CNT);
  modport slave  (input  iAUD_BCK, iAUD_LRCK, iAUD_DAT,
                  output oLEFT, oRIGHT, oSAMPLE_VALID, oFRAME_ERR, oERR_CNT);
`else
  modport master (output iAUD_BCK, iAUD_LRCK, iAUD_DAT,
                  input  oLEFT, oRIGHT, oSAMPLE_VALID);
  modport slave  (input  iAUD_BCK, iAUD_LRCK, iAUD_DAT,
                  output oLEFT, oRIGHT, oSAMPLE_VALID);
`endif
endinterface

// File: rtl/aud_sync_edge.sv
// aud_sync_edge: multi-flop synchroniser for an asynchronous input with rise/fall detection
module aud_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic AUDIO_CLK,
  input  logic reset_reg,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync;
  logic              prev;
  always_ff @(posedge AUDIO_CLK)
    if (reset_reg) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      prev <= sync[STAGES-1];
    end
  assign q    = sync[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;
endmodule

// File: rtl/aud_i2s_rx.sv
// aud_i2s_rx: I2S slave receiver recovering stereo pairs; AUD_RX_FRAME_CHECK_EN adds slot-length error reporting
module aud_i2s_rx
  import aud_if_pkg::*;
#(
  parameter int DATA_WIDTH  = AUD_DATA_WIDTH,
  parameter int SLOT_BITS   = AUD_SLOT_BITS,
  parameter int SYNC_STAGES = AUD_SYNC_STAGES
) (
  input logic         AUDIO_CLK,
  input logic         reset_reg,
  aud_i2s_rx_if.slave bus
);
  localparam int CW = cnt_width(SLOT_BITS);
  localparam logic [CW-1:0] DW_C = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] SB_C = CW'(SLOT_BITS);
  logic                  bck_rise, bck_q, bck_fall, lrck_s, lrck_rise, lrck_fall, dat_s, dat_rise, dat_fall;
  logic                  unused_edges;
  logic                  lrck_prev, lrck_edge, left_ok;
  logic [CW-1:0]         bit_cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] shreg, left_hold, word, left_q, right_q;
  logic                  valid_q;
  logic                  active, shift_en, word_done, left_done, right_done, load, left_drop;
  rx_state_e             state, state_nxt;
  aud_sync_edge #(.STAGES(SYNC_STAGES)) u_bck (
    .AUDIO_CLK(AUDIO_CLK), .reset_reg(reset_reg), .d(bus.iAUD_BCK),
    .q(bck_q), .rise(bck_rise), .fall(bck_fall)
  );
  aud_sync_edge #(.STAGES(SYNC_STAGES)) u_lrck (
    .AUDIO_CLK(AUDIO_CLK), .reset_reg(reset_reg), .d(bus.iAUD_LRCK),
    .q(lrck_s), .rise(lrck_rise), .fall(lrck_fall)
  );
  aud_sync_edge #(.STAGES(SYNC_STAGES)) u_dat (
    .AUDIO_CLK(AUDIO_CLK), .reset_reg(reset_reg), .d(bus.iAUD_DAT),
    .q(dat_s), .rise(dat_rise), .fall(dat_fall)
  );
  assign unused_edges = ^{bck_q, bck_fall, lrck_rise, lrck_fall, dat_rise, dat_fall};
  // LRCK is only meaningful at BCK rises, so edges compare against the value seen at the previous rise
  assign lrck_edge = lrck_s ^ lrck_prev;
  assign cnt_nxt   = lrck_edge ? '0 : (bit_cnt == SB_C ? bit_cnt : bit_cnt + CW'(1));
  always_ff @(posedge AUDIO_CLK)
    state <= reset_reg ? SYNC_WAIT : state_nxt;
  always_comb
    state_nxt = (bck_rise && lrck_edge && (state != SYNC_WAIT || !lrck_s))
              ? (lrck_s ? RX_RIGHT : RX_LEFT) : state;
  always_comb begin
    active     = bck_rise && state != SYNC_WAIT;
    shift_en   = active && !lrck_edge && cnt_nxt <= DW_C;
    word       = {shreg[DATA_WIDTH-2:0], dat_s};
    word_done  = shift_en && cnt_nxt == DW_C;
    left_done  = word_done && state == RX_LEFT;
    right_done = word_done && state == RX_RIGHT;
    load       = right_done && left_ok;
    left_drop  = active && lrck_edge && (!lrck_s || bit_cnt < DW_C);
  end
  // a held left word survives only a full left slot followed by the matching right word
  always_ff @(posedge AUDIO_CLK)
    if (reset_reg) begin
      lrck_prev <= 1'b0;
      bit_cnt   <= '0;
      shreg     <= '0;
      left_hold <= '0;
      left_ok   <= 1'b0;
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= load;
      left_ok <= left_done ? 1'b1 : (left_drop || load) ? 1'b0 : left_ok;
      if (bck_rise) begin
        lrck_prev <= lrck_s;
        bit_cnt   <= cnt_nxt;
      end
      if (shift_en) shreg <= word;
      if (left_done) left_hold <= word;
      if (load) begin
        left_q  <= left_hold;
        right_q <= word;
      end
    end
  assign bus.oLEFT         = left_q;
  assign bus.oRIGHT        = right_q;
  assign bus.oSAMPLE_VALID = valid_q;
`ifdef AUD_RX_FRAME_CHECK_EN
  logic       slot_err, frame_err_q;
  logic [7:0] err_cnt_q;
  assign slot_err = active && lrck_edge && bit_cnt != SB_C - CW'(1);
  always_ff @(posedge AUDIO_CLK)
    if (reset_reg) begin
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      frame_err_q <= slot_err;
      err_cnt_q   <= err_cnt_q + 8'(slot_err && err_cnt_q != 8'hFF);
    end
  assign bus.oFRAME_ERR = frame_err_q;
  assign bus.oERR_CNT   = err_cnt_q;
`endif
endmodule

// File: tb/tb_aud_i2s_rx.sv
// tb_aud_i2s_rx: directed bench for 16- and 24-bit receivers sharing one I2S stream; AUD_RX_FRAME_CHECK_EN enables error-port checks
module tb_aud_i2s_rx;
  logic AUDIO_CLK = 1'b0;
  logic reset_reg = 1'b1;
  logic bck = 1'b0, lrck = 1'b0, dat = 1'b0;
  int checks = 0, failures = 0;
  int cyc = 0, v16 = 0, v24 = 0, last16 = 0, bad_int = 0, errp = 0;
  always #5 AUDIO_CLK = ~AUDIO_CLK;
  aud_i2s_rx_if #(.DATA_WIDTH(16)) bus16();
  aud_i2s_rx_if #(.DATA_WIDTH(24)) bus24();
  assign bus16.iAUD_BCK = bck;
  assign bus16.iAUD_LRCK = lrck;
  assign bus16.iAUD_DAT = dat;
  assign bus24.iAUD_BCK = bck;
  assign bus24.iAUD_LRCK = lrck;
  assign bus24.iAUD_DAT = dat;
  aud_i2s_rx #(.DATA_WIDTH(16)) dut (.AUDIO_CLK(AUDIO_CLK), .reset_reg(reset_reg), .bus(bus16.slave));
  aud_i2s_rx #(.DATA_WIDTH(24)) dut24 (.AUDIO_CLK(AUDIO_CLK), .reset_reg(reset_reg), .bus(bus24.slave));
  always @(negedge AUDIO_CLK) begin
    cyc++;
    if (bus16.oSAMPLE_VALID === 1'b1) begin
      if (last16 != 0 && cyc - last16 != 384) bad_int++;
      last16 = cyc;
      v16++;
    end
    if (bus24.oSAMPLE_VALID === 1'b1) v24++;
`ifdef AUD_RX_FRAME_CHECK_EN
    if (bus16.oFRAME_ERR === 1'b1) errp++;
`endif
  end
  task automatic bck_cycle(input logic lr, input logic d);
    bck = 1'b0;
    lrck = lr;
    dat = d;
    repeat (3) @(negedge AUDIO_CLK);
    bck = 1'b1;
    repeat (3) @(negedge AUDIO_CLK);
  endtask
  task automatic send_slot(input logic lr, input logic [31:0] s, input int k0, input int k1);
    for (int k = k0; k < k1; k++) bck_cycle(lr, k == 0 ? 1'b0 : s[32-k]);
  endtask
  task automatic send_frame(input logic [31:0] l, input logic [31:0] r);
    send_slot(1'b0, l, 0, 32);
    send_slot(1'b1, r, 0, 32);
  endtask
  task automatic test_reset;
    reset_reg = 1'b1;
    repeat (4) @(negedge AUDIO_CLK);
    checks++; if (bus16.oLEFT !== 16'h0) begin failures++; $display("FAIL reset_left got %h want 0000", bus16.oLEFT); end
    checks++; if (bus16.oRIGHT !== 16'h0) begin failures++; $display("FAIL reset_right got %h want 0000", bus16.oRIGHT); end
    checks++; if (bus16.oSAMPLE_VALID !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", bus16.oSAMPLE_VALID); end
    checks++; if (bus24.oLEFT !== 24'h0) begin failures++; $display("FAIL reset_left24 got %h want 000000", bus24.oLEFT); end
`ifdef AUD_RX_FRAME_CHECK_EN
    checks++; if (bus16.oERR_CNT !== 8'h0) begin failures++; $display("FAIL reset_errcnt got %0d want 0", bus16.oERR_CNT); end
`endif
    reset_reg = 1'b0;
  endtask
  task automatic test_frame;
    int n0;
    send_frame(32'h1111_0000, 32'h2222_0000);
    n0 = v16;
    send_frame({16'hA5C3, 16'h0}, {16'h3C5A, 16'h0});
    checks++; if (v16 - n0 != 1) begin failures++; $display("FAIL frame_pulses got %0d want 1", v16 - n0); end
    checks++; if (bus16.oLEFT !== 16'hA5C3) begin failures++; $display("FAIL frame_left got %h want a5c3", bus16.oLEFT); end
    checks++; if (bus16.oRIGHT !== 16'h3C5A) begin failures++; $display("FAIL frame_right got %h want 3c5a", bus16.oRIGHT); end
  endtask
  task automatic test_back_to_back;
    logic [15:0] lv [8] = '{16'h0001, 16'hFFFF, 16'h1234, 16'h8001, 16'h0F0F, 16'hC0DE, 16'h5555, 16'hBEEF};
    logic [15:0] rv [8] = '{16'hFFFE, 16'h0000, 16'h4321, 16'h7FFE, 16'hF0F0, 16'hDEC0, 16'hAAAA, 16'hFEED};
    int n0, b0;
    n0 = v16;
    b0 = bad_int;
    for (int i = 0; i < 8; i++) send_frame({lv[i], 16'h0}, {rv[i], 16'h0});
    checks++; if (v16 - n0 != 8) begin failures++; $display("FAIL b2b_pulses got %0d want 8", v16 - n0); end
    checks++; if (bad_int != b0) begin failures++; $display("FAIL b2b_interval got %0d bad intervals want 0", bad_int - b0); end
    checks++; if (bus16.oLEFT !== 16'hBEEF) begin failures++; $display("FAIL b2b_left got %h want beef", bus16.oLEFT); end
    checks++; if (bus16.oRIGHT !== 16'hFEED) begin failures++; $display("FAIL b2b_right got %h want feed", bus16.oRIGHT); end
  endtask
  task automatic test_extremes;
    send_frame({16'h8000, 16'h0}, {16'h7FFF, 16'h0});
    checks++; if (bus16.oLEFT !== 16'h8000) begin failures++; $display("FAIL ext_left got %h want 8000", bus16.oLEFT); end
    checks++; if (bus16.oRIGHT !== 16'h7FFF) begin failures++; $display("FAIL ext_right got %h want 7fff", bus16.oRIGHT); end
    checks++; if (bus24.oLEFT !== 24'h800000) begin failures++; $display("FAIL ext_left24 got %h want 800000", bus24.oLEFT); end
    checks++; if (bus24.oRIGHT !== 24'h7FFF00) begin failures++; $display("FAIL ext_right24 got %h want 7fff00", bus24.oRIGHT); end
  endtask
  task automatic test_reset_mid;
    int n0;
    send_slot(1'b0, {16'h1111, 16'h0}, 0, 32);
    send_slot(1'b1, {16'h2222, 16'h0}, 0, 10);
    bck = 1'b0;
    reset_reg = 1'b1;
    repeat (3) @(negedge AUDIO_CLK);
    checks++; if (bus16.oLEFT !== 16'h0) begin failures++; $display("FAIL rstmid_left got %h want 0000", bus16.oLEFT); end
    checks++; if (bus16.oRIGHT !== 16'h0) begin failures++; $display("FAIL rstmid_right got %h want 0000", bus16.oRIGHT); end
    reset_reg = 1'b0;
    n0 = v16;
    send_slot(1'b1, {16'h2222, 16'h0}, 10, 32);
    checks++; if (v16 != n0) begin failures++; $display("FAIL rstmid_nopulse got %0d want 0", v16 - n0); end
    send_frame({16'h1357, 16'h0}, {16'h2468, 16'h0});
    checks++; if (v16 - n0 != 1) begin failures++; $display("FAIL rstmid_pulses got %0d want 1", v16 - n0); end
    checks++; if (bus16.oLEFT !== 16'h1357) begin failures++; $display("FAIL rstmid_left2 got %h want 1357", bus16.oLEFT); end
    checks++; if (bus16.oRIGHT !== 16'h2468) begin failures++; $display("FAIL rstmid_right2 got %h want 2468", bus16.oRIGHT); end
  endtask
  task automatic test_right_first;
    int n0;
    bck = 1'b0;
    lrck = 1'b1;
    reset_reg = 1'b1;
    repeat (4) @(negedge AUDIO_CLK);
    reset_reg = 1'b0;
    n0 = v16;
    send_slot(1'b1, {16'h7777, 16'h0}, 0, 32);
    checks++; if (v16 != n0) begin failures++; $display("FAIL rfirst_nopulse got %0d want 0", v16 - n0); end
    send_frame({16'h0F0F, 16'h0}, {16'hF0F0, 16'h0});
    checks++; if (v16 - n0 != 1) begin failures++; $display("FAIL rfirst_pulses got %0d want 1", v16 - n0); end
    checks++; if (bus16.oLEFT !== 16'h0F0F) begin failures++; $display("FAIL rfirst_left got %h want 0f0f", bus16.oLEFT); end
    checks++; if (bus16.oRIGHT !== 16'hF0F0) begin failures++; $display("FAIL rfirst_right got %h want f0f0", bus16.oRIGHT); end
  endtask
  task automatic test_short_slot;
    int n0, e0;
    n0 = v16;
    e0 = errp;
    send_slot(1'b0, {16'hAAAA, 16'h0}, 0, 10);
    send_slot(1'b1, {16'h5555, 16'h0}, 0, 32);
    checks++; if (v16 != n0) begin failures++; $display("FAIL short_nopulse got %0d want 0", v16 - n0); end
    checks++; if (bus16.oRIGHT !== 16'hF0F0) begin failures++; $display("FAIL short_hold got %h want f0f0", bus16.oRIGHT); end
    send_frame({16'h1234, 16'h0}, {16'h4321, 16'h0});
    checks++; if (v16 - n0 != 1) begin failures++; $display("FAIL short_next got %0d want 1", v16 - n0); end
    checks++; if (bus16.oLEFT !== 16'h1234) begin failures++; $display("FAIL short_left got %h want 1234", bus16.oLEFT); end
`ifdef AUD_RX_FRAME_CHECK_EN
    checks++; if (errp - e0 != 1) begin failures++; $display("FAIL short_errpulse got %0d want 1", errp - e0); end
    checks++; if (bus16.oERR_CNT !== 8'd1) begin failures++; $display("FAIL short_errcnt got %0d want 1", bus16.oERR_CNT); end
`else
    checks++; if (errp != e0) begin failures++; $display("FAIL short_errpulse got %0d want 0", errp - e0); end
`endif
  endtask
  task automatic test_24bit;
    int n0;
    n0 = v24;
    send_frame({24'h123456, 8'hFF}, {24'hFEDCBA, 8'hFF});
    checks++; if (v24 - n0 != 1) begin failures++; $display("FAIL w24_pulses got %0d want 1", v24 - n0); end
    checks++; if (bus24.oLEFT !== 24'h123456) begin failures++; $display("FAIL w24_left got %h want 123456", bus24.oLEFT); end
    checks++; if (bus24.oRIGHT !== 24'hFEDCBA) begin failures++; $display("FAIL w24_right got %h want fedcba", bus24.oRIGHT); end
    checks++; if (bus16.oLEFT !== 16'h1234) begin failures++; $display("FAIL w24_left16 got %h want 1234", bus16.oLEFT); end
    checks++; if (bus16.oRIGHT !== 16'hFEDC) begin failures++; $display("FAIL w24_right16 got %h want fedc", bus16.oRIGHT); end
  endtask
  initial begin
    test_reset;
    test_frame;
    test_back_to_back;
    test_extremes;
    test_reset_mid;
    test_right_first;
    test_short_slot;
    test_24bit;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
